instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 SHALL have parameter BUBBLE, default 9'b1011_00000, machine word driven in place of an instruction when not running; its opcode decodes with no register or memory write.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins program execution at address 0.
REQ-006 SHALL have port prog_addr  output  PC_W  instruction memory address, equal to pc.
REQ-007 SHALL have port prog_data  input  9  instruction memory word, combinational read of prog_addr.
REQ-008 SHALL have port alu_zero  input  1  ALU result-zero flag for the instruction currently issued.
REQ-009 SHALL have port alu_neg  input  1  ALU result-negative flag for the instruction currently issued.
REQ-010 SHALL have port mach_code  output  9  machine word to the control decoder; its opcode field is [8:5].
REQ-011 SHALL have port valid  output  1  high while mach_code carries a real instruction.
REQ-012 SHALL have port done  output  1  high from program end until the next start or reset.
REQ-013 SHALL have port cycle_count  output  16  count of executed instructions (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL move IDLE->RUN on start=1 and set pc=0; start in RUN SHALL be ignored; start in DONE SHALL behave as in IDLE.
REQ-016 In RUN: mach_code=prog_data and valid=1; in IDLE/DONE: mach_code=BUBBLE and valid=0.
REQ-017 SHALL issue one instruction per cycle with zero fetch latency: prog_data at pc is on mach_code in the same cycle.
REQ-018 Opcode 4'b0101 (cmp) in RUN SHALL latch zero_f<=alu_zero and neg_f<=alu_neg at that edge; no other opcode SHALL alter zero_f or neg_f.
REQ-019 Opcode 4'b1111 (bne) SHALL be taken when zero_f=0; opcode 4'b1010 (bge) SHALL be taken when neg_f=0.
REQ-020 Taken branch: pc<=pc+sign_extend(mach_code[4:0]) modulo 2^PC_W; offset 0 is legal and holds pc (self-loop).
REQ-021 Not-taken branch and every other non-halt opcode: pc<=pc+1 modulo 2^PC_W.
REQ-022 Opcode 4'b1000 (halt) SHALL move RUN->DONE and leave pc unchanged; done SHALL assert the following cycle.
REQ-023 Sequential increment from pc=2^PC_W-1 SHALL move RUN->DONE and not wrap execution; a branch whose target wraps SHALL be followed normally.
REQ-024 Branch decisions SHALL use flags latched at earlier edges only; a cmp's flags SHALL affect the next branch, never the cmp cycle itself.

Reset
REQ-025 reset_n=0 at an edge SHALL force IDLE, pc=0, zero_f=0, neg_f=0, done=0, cycle_count=0, overriding start and any in-flight instruction.
REQ-026 Reset during RUN SHALL abort the program; no further instruction SHALL be issued until a new start.

Configuration
REQ-027 Macro FETCH_CYCLE_COUNT_EN defined: cycle_count SHALL increment by 1 at each RUN edge, saturate at 16'hFFFF, clear on start and reset, and hold in DONE.
REQ-028 Macro FETCH_CYCLE_COUNT_EN undefined: cycle_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-029 Reset, then start; program add,add,halt at 0..2 -> mach_code follows words 0,1,2 with valid=1; done=1 from cycle 4; cycle_count=3 when FETCH_CYCLE_COUNT_EN is defined.
REQ-030 cmp with alu_zero=0 at 0, bne offset +3 at 1 -> next pc=4; repeat with alu_zero=1 -> next pc=2.
REQ-031 cmp with alu_neg=1, then bge offset -2 (5'b11110) at pc=5 -> not taken, pc=6; with alu_neg=0 -> pc=3.
REQ-032 Straight-line code to pc=1023 with PC_W=10 -> RUN->DONE after address 1023 issues; prog_addr stays 1023; valid=0.
REQ-033 reset_n=0 for one edge while pc=7 in RUN -> next cycle IDLE, pc=0, mach_code=BUBBLE, flags cleared; start mid-RUN -> pc sequence unchanged.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-issue, zero-latency fetch and branch unit.
// Build option FETCH_CYCLE_COUNT_EN adds a saturating executed-instruction counter.
module instr_fetch #(
  parameter int unsigned PC_W   = 10,
  parameter logic [8:0]  BUBBLE = 9'b1011_00000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic [PC_W-1:0] prog_addr,
  input  logic [8:0]      prog_data,
  input  logic            alu_zero,
  input  logic            alu_neg,
  output logic [8:0]      mach_code,
  output logic            valid,
  output logic            done,
  output logic [15:0]     cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b1111;
  localparam logic [3:0] OP_BGE  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1000;

  localparam logic [PC_W-1:0] PC_MAX = '1;
  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;

  logic [3:0]      opcode;
  logic [PC_W-1:0] offset;
  logic            taken;

  assign opcode = prog_data[8:5];
  assign offset = PC_W'($signed(prog_data[4:0]));

  // branches only ever see flags latched at an earlier edge
  assign taken = ((opcode == OP_BNE) && !zero_q) ||
                 ((opcode == OP_BGE) && !neg_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (opcode == OP_CMP) begin
          zero_d = alu_zero;
          neg_d  = alu_neg;
        end
        if (opcode == OP_HALT) begin
          state_d = DONE;
        end else if (taken) begin
          pc_d = pc_q + offset;
        end else if (pc_q == PC_MAX) begin
          // falling off the end stops rather than wrapping
          state_d = DONE;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign prog_addr = pc_q;
  assign valid     = (state_q == RUN);
  assign mach_code = valid ? prog_data : BUBBLE;
  assign done      = (state_q == DONE);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (start) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized + directed programs against a reference
// model; expected per-cycle outputs are queued and checked by a monitor.
module tb_instr_fetch;

  localparam int unsigned PC_W  = 10;
  localparam int          DEPTH = 1 << PC_W;
  localparam int          MASK  = DEPTH - 1;
  localparam logic [8:0]  BUB   = 9'b1011_00000;

  localparam logic [8:0] W_ADD  = 9'b0000_00000;
  localparam logic [8:0] W_CMP  = 9'b0101_00000;
  localparam logic [8:0] W_HALT = 9'b1000_00000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] prog_addr;
  logic [8:0]      prog_data;
  logic            alu_zero = 1'b0;
  logic            alu_neg = 1'b0;
  logic [8:0]      mach_code;
  logic            valid;
  logic            done;
  logic [15:0]     cycle_count;

  logic [8:0] mem [DEPTH];

  instr_fetch #(.PC_W(PC_W), .BUBBLE(BUB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .alu_zero(alu_zero),
    .alu_neg(alu_neg),
    .mach_code(mach_code),
    .valid(valid),
    .done(done),
    .cycle_count(cycle_count)
  );

  assign prog_data = mem[prog_addr];

  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    bit         vld;
    logic [8:0] code;
    bit         dn;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: program-level view of the fetch unit.
  bit running = 0, finished = 0, zf = 0, nf = 0;
  int pc_m = 0, cnt_m = 0;

  always @(posedge clk) begin
    logic [8:0] w;
    int op, off;
    bit take;
    exp_t e;
    if (!reset_n) begin
      running = 0; finished = 0; pc_m = 0;
      zf = 0; nf = 0; cnt_m = 0;
    end else if (running) begin
      w = mem[pc_m];
      op = int'(w[8:5]);
      off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
      cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
      take = (op == 15 && !zf) || (op == 10 && !nf);
      if (op == 5) begin zf = alu_zero; nf = alu_neg; end
      if (op == 8) begin
        running = 0; finished = 1;
      end else if (take) begin
        pc_m = (pc_m + off) & MASK;
      end else if (pc_m == MASK) begin
        running = 0; finished = 1;
      end else begin
        pc_m = pc_m + 1;
      end
    end else if (start) begin
      running = 1; finished = 0; pc_m = 0; cnt_m = 0;
    end
    e.addr = pc_m;
    e.vld  = running;
    e.code = running ? mem[pc_m] : BUB;
    e.dn   = finished;
`ifdef FETCH_CYCLE_COUNT_EN
    e.cnt  = cnt_m;
`else
    e.cnt  = 0;
`endif
    q.push_back(e);
  end

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("prog_addr", int'(prog_addr), e.addr);
      chk("valid", int'(valid), int'(e.vld));
      chk("mach_code", int'(mach_code), int'(e.code));
      chk("done", int'(done), int'(e.dn));
      chk("cycle_count", int'(cycle_count), e.cnt);
    end
  end

  task automatic step(input bit rn, input bit st, input bit z, input bit n);
    @(negedge clk);
    #2;
    reset_n  = rn;
    start    = st;
    alu_zero = z;
    alu_neg  = n;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic fill(input logic [8:0] w);
    for (int i = 0; i < DEPTH; i++) mem[i] = w;
  endtask

  // reset, settle in IDLE, then load a fresh image
  task automatic reset_and_fill(input logic [8:0] w);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    fill(w);
  endtask

  task automatic go();
    step(1'b1, 1'b1, 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [8:0] rand_word();
    logic [3:0] ops [8];
    logic [3:0] op;
    ops = '{4'b0000, 4'b0000, 4'b0101, 4'b0101,
            4'b1111, 4'b1010, 4'b0011, 4'b1000};
    op = ops[$urandom_range(7)];
    if (op == 4'b1000 && $urandom_range(3) != 0) op = 4'b0001;
    return {op, 5'($urandom)};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fill(W_HALT);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // add, add, halt
    reset_and_fill(W_HALT);
    mem[0] = W_ADD; mem[1] = W_ADD; mem[2] = W_HALT;
    go();
    idle(6);

    // cmp zero=0, bne +3 -> 4 ; then cmp zero=1 -> falls to 2
    for (int z = 0; z < 2; z++) begin
      reset_and_fill(W_HALT);
      mem[0] = W_CMP;
      mem[1] = 9'b1111_00011;
      mem[2] = W_ADD;
      go();
      step(1'b1, 1'b0, 1'(z), 1'($urandom));
      idle(6);
    end

    // cmp neg, bge -2 at pc 5
    for (int n = 1; n >= 0; n--) begin
      reset_and_fill(W_ADD);
      mem[0] = W_CMP;
      mem[5] = 9'b1010_11110;
      mem[6] = W_HALT;
      mem[7] = W_HALT;
      go();
      step(1'b1, 1'b0, 1'($urandom), 1'(n));
      idle(12);
    end

    // taken branch wrapping below 0 to the top address
    reset_and_fill(W_HALT);
    mem[0] = W_CMP;
    mem[1] = 9'b1111_11110;
    mem[MASK] = W_ADD;
    go();
    step(1'b1, 1'b0, 1'b0, 1'($urandom));
    idle(6);

    // straight-line run off the end of memory
    reset_and_fill(W_ADD);
    go();
    idle(DEPTH + 8);
    go();
    idle(4);

    // mid-run start ignored, then reset at pc 7
    reset_and_fill(W_ADD);
    go();
    idle(3);
    go();
    idle(3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    go();
    idle(5);

    // random programs with random start/reset interference
    for (int r = 0; r < 40; r++) begin
      reset_and_fill(W_ADD);
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
      go();
      for (int c = 0; c < int'($urandom_range(150, 20)); c++) begin
        case ($urandom_range(40))
          0: step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
          1, 2: go();
          default: idle(1);
        endcase
      end
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
